// File: rtl/i2s_stereo_arbiter_pkg.sv
// i2s_pkg: definitions shared by the I2S stereo arbiter and its sample FIFOs.
//   CH_L / CH_R  : channel codes. They are also the m_axis_tid values.
//   SAMPLE_W     : width of one captured sample.
//   arb_state_e  : arbiter state (RUN / FLUSH).
//   beat_t       : one output beat (data, channel id, frame-end flag).
package i2s_pkg;

    localparam logic CH_L     = 1'b0;
    localparam logic CH_R     = 1'b1;
    localparam int   SAMPLE_W = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] data;
        logic                id;
        logic                last;
    } beat_t;

endpackage

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: single-clock FIFO for one audio channel. Storage is registered.
//   clk, rst   : clock and synchronous active-high reset
//   flush      : empties the FIFO this cycle. It overrides push and pop.
//   push/wdata : write request and data. A push while full is refused unless a pop
//                happens in the same cycle.
//   pop        : read request. It is ignored while empty.
//   rdata      : head entry. It is meaningful only while not empty.
//   full/empty : status flags
//   overflow   : a push was refused because the FIFO is full
module i2s_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    // Each pointer is an index plus one wrap bit. Pointers are equal when the FIFO
    // is empty. They differ only in the wrap bit when it is full.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty && !flush;
    // A read in the same cycle frees a slot, so a write while full is still taken.
    assign do_push  = push && !flush && (!full || do_pop);
    assign overflow = push && !flush && full && !do_pop;
    assign rdata    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full, the write slot is the slot being read. The head value still
    // drives rdata this cycle and is replaced only at the clock edge.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/i2s_stereo_arbiter.sv
// i2s_stereo_arbiter: buffers the left and right I2S capture streams and
// interleaves them L,R,L,R onto one AXI-Stream master. tid gives the channel and
// tlast is high on the right beat. The upstream streams ignore backpressure, so
// overflowing samples are dropped and counted. If L/R pairing is lost (the granted
// FIFO is empty while the other is full), both FIFOs are flushed for one cycle.
//   sys_clk, sys_rst      : clock and synchronous active-high reset
//   enable                : 0 flushes the FIFOs, discards inputs and resets grant to L
//   s_axis_*_l / _r       : per-channel sample strobes. tready is informational only.
//   m_axis_*              : interleaved output stream
//   stat_clear            : zeros drop_cnt_l/r and resync_cnt (saturating counters)
// Optional macro I2S_ARB_SWAP_EN adds the input swap_lr. While enable=0 it is
// captured, and the value present when enable rises is held. When that value is 1,
// the right input feeds tid=0.
module i2s_stereo_arbiter
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] s_axis_tdata_l,
    input  logic                s_axis_tvalid_l,
    output logic                s_axis_tready_l,
    input  logic [SAMPLE_W-1:0] s_axis_tdata_r,
    input  logic                s_axis_tvalid_r,
    output logic                s_axis_tready_r,
    output logic [SAMPLE_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tid,
    output logic                m_axis_tlast,
`ifdef I2S_ARB_SWAP_EN
    input  logic                swap_lr,
`endif
    input  logic                stat_clear,
    output logic [CNT_W-1:0]    drop_cnt_l,
    output logic [CNT_W-1:0]    drop_cnt_r,
    output logic [CNT_W-1:0]    resync_cnt
);
    arb_state_e                 state;
    logic                       grant;
    logic                       swap, run, flush, fire, desync, drop_l, drop_r;
    logic [1:0][SAMPLE_W-1:0]   in_data, fifo_rdata;
    logic [1:0]                 in_valid, fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf;
    logic [1:0]                 fifo_src;
    beat_t                      beat;

`ifdef I2S_ARB_SWAP_EN
    logic swap_q;
    always_ff @(posedge sys_clk) begin
        if (sys_rst)     swap_q <= 1'b0;
        else if (!enable) swap_q <= swap_lr;
    end
    assign swap = swap_q;
`else
    assign swap = 1'b0;
`endif

    assign in_data  = {s_axis_tdata_r, s_axis_tdata_l};
    assign in_valid = {s_axis_tvalid_r, s_axis_tvalid_l};
    assign run      = enable && (state == RUN);
    assign flush    = !enable || (state == FLUSH);

    // Index 0 is always the tid=0 FIFO. The swap changes only which input feeds it.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        assign fifo_src[ch]  = swap ^ 1'(ch);
        assign fifo_push[ch] = run && in_valid[fifo_src[ch]];
        assign fifo_pop[ch]  = fire && (grant == 1'(ch));

        i2s_sample_fifo #(.DEPTH(DEPTH), .WIDTH(SAMPLE_W)) u_fifo (
            .clk      (sys_clk),
            .rst      (sys_rst),
            .flush    (flush),
            .push     (fifo_push[ch]),
            .wdata    (in_data[fifo_src[ch]]),
            .pop      (fifo_pop[ch]),
            .rdata    (fifo_rdata[ch]),
            .full     (fifo_full[ch]),
            .empty    (fifo_empty[ch]),
            .overflow (fifo_ovf[ch])
        );
    end

    // The left input feeds FIFO index 'swap'. The right input feeds the other FIFO.
    assign drop_l          = fifo_ovf[swap];
    assign drop_r          = fifo_ovf[~swap];
    assign s_axis_tready_l = !fifo_full[swap];
    assign s_axis_tready_r = !fifo_full[~swap];

    assign m_axis_tvalid = run && !fifo_empty[grant];
    assign fire          = m_axis_tvalid && m_axis_tready;
    assign desync        = run && fifo_empty[grant] && fifo_full[~grant];

    // Data is forced to zero while idle, so an empty FIFO never shows stale storage.
    assign beat.data    = m_axis_tvalid ? fifo_rdata[grant] : '0;
    assign beat.id      = grant;
    assign beat.last    = grant;
    assign m_axis_tdata = beat.data;
    assign m_axis_tid   = beat.id;
    assign m_axis_tlast = beat.last;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !enable) begin
            state <= RUN;
            grant <= CH_L;
        end else begin
            case (state)
                RUN: begin
                    if (desync)    state <= FLUSH;
                    else if (fire) grant <= ~grant;
                end
                FLUSH: begin
                    state <= RUN;
                    grant <= CH_L;
                end
                default: begin
                    state <= RUN;
                    grant <= CH_L;
                end
            endcase
        end
    end

    // A clear and an increment in the same cycle leave the counter at 1.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic clr);
        if (clr)               return inc ? CNT_W'(1) : '0;
        if (inc && (c != '1))  return c + 1'b1;
        return c;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drop_cnt_l <= '0;
            drop_cnt_r <= '0;
            resync_cnt <= '0;
        end else begin
            drop_cnt_l <= cnt_next(drop_cnt_l, drop_l, stat_clear);
            drop_cnt_r <= cnt_next(drop_cnt_r, drop_r, stat_clear);
            resync_cnt <= cnt_next(resync_cnt, desync, stat_clear);
        end
    end

endmodule

// File: tb/tb_i2s_stereo_arbiter.sv
// Bench for i2s_stereo_arbiter with the default build (no swap port). A queue-based
// model of the two channel buffers predicts the outputs, and one negedge process
// compares them every cycle. Directed scenarios also check the logged beat
// sequence and counter values against hand-computed literals.
module tb_i2s_stereo_arbiter;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             enable  = 1'b1;
    logic [7:0]       s_axis_tdata_l = '0, s_axis_tdata_r = '0;
    logic             s_axis_tvalid_l = 1'b0, s_axis_tvalid_r = 1'b0;
    logic             s_axis_tready_l, s_axis_tready_r;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid, m_axis_tid, m_axis_tlast;
    logic             m_axis_tready = 1'b1;
    logic             stat_clear = 1'b0;
    logic [CNT_W-1:0] drop_cnt_l, drop_cnt_r, resync_cnt;

    i2s_stereo_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .enable          (enable),
        .s_axis_tdata_l  (s_axis_tdata_l),
        .s_axis_tvalid_l (s_axis_tvalid_l),
        .s_axis_tready_l (s_axis_tready_l),
        .s_axis_tdata_r  (s_axis_tdata_r),
        .s_axis_tvalid_r (s_axis_tvalid_r),
        .s_axis_tready_r (s_axis_tready_r),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tid      (m_axis_tid),
        .m_axis_tlast    (m_axis_tlast),
        .stat_clear      (stat_clear),
        .drop_cnt_l      (drop_cnt_l),
        .drop_cnt_r      (drop_cnt_r),
        .resync_cnt      (resync_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model state: channel buffers as queues, next channel owed, pending flush, counters.
    logic [7:0] ql[$], qr[$];
    logic       m_grant = 1'b0;
    logic       m_flush = 1'b0;
    int         m_dl = 0, m_dr = 0, m_rs = 0;
    logic       started = 1'b0;
    logic [8:0] beat_log[$], exp_q[$];

    logic       m_tv, m_fire, m_desync, m_dropl, m_dropr, prev_stall = 1'b0, prev_tid;
    logic [7:0] m_head, prev_data;
    int         sz_g, sz_o;

    function automatic int sat(input int c, input logic inc, input logic clr);
        if (clr) return inc ? 1 : 0;
        if (inc && c < 255) return c + 1;
        return c;
    endfunction

    always @(negedge sys_clk) begin
        if (started) begin
            sz_g = m_grant ? qr.size() : ql.size();
            sz_o = m_grant ? ql.size() : qr.size();
            m_tv = enable && !m_flush && (sz_g > 0);
            chk("tvalid", m_axis_tvalid, m_tv);
            if (m_tv) begin
                m_head = m_grant ? qr[0] : ql[0];
                chk("tdata", m_axis_tdata, m_head);
                chk("tid",   m_axis_tid,   m_grant);
                chk("tlast", m_axis_tlast, m_grant);
            end
            chk("tready_l", s_axis_tready_l, ql.size() < DEPTH);
            chk("tready_r", s_axis_tready_r, qr.size() < DEPTH);
            chk("drop_cnt_l", drop_cnt_l, m_dl);
            chk("drop_cnt_r", drop_cnt_r, m_dr);
            chk("resync_cnt", resync_cnt, m_rs);
            // A stalled beat must be held until it is taken.
            if (prev_stall && enable && !sys_rst) begin
                chk("stall_hold_data", m_axis_tdata, prev_data);
                chk("stall_hold_tid",  m_axis_tid,   prev_tid);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready && !sys_rst;
            prev_data  = m_axis_tdata;
            prev_tid   = m_axis_tid;
            if (m_axis_tvalid && m_axis_tready && !sys_rst)
                beat_log.push_back({m_axis_tid, m_axis_tdata});

            // Advance the model across the coming clock edge.
            if (sys_rst) begin
                ql.delete(); qr.delete();
                m_grant = 1'b0; m_flush = 1'b0;
                m_dl = 0; m_dr = 0; m_rs = 0;
            end else begin
                m_fire   = m_tv && m_axis_tready;
                m_desync = enable && !m_flush && (sz_g == 0) && (sz_o == DEPTH);
                m_dropl  = 1'b0;
                m_dropr  = 1'b0;
                if (!enable || m_flush) begin
                    ql.delete(); qr.delete();
                    m_grant = 1'b0;
                    m_flush = 1'b0;
                end else begin
                    if (m_fire) begin
                        if (m_grant) void'(qr.pop_front());
                        else         void'(ql.pop_front());
                        m_grant = ~m_grant;
                    end
                    if (s_axis_tvalid_l) begin
                        if (ql.size() < DEPTH) ql.push_back(s_axis_tdata_l);
                        else                   m_dropl = 1'b1;
                    end
                    if (s_axis_tvalid_r) begin
                        if (qr.size() < DEPTH) qr.push_back(s_axis_tdata_r);
                        else                   m_dropr = 1'b1;
                    end
                    if (m_desync) m_flush = 1'b1;
                end
                m_dl = sat(m_dl, m_dropl, stat_clear);
                m_dr = sat(m_dr, m_dropr, stat_clear);
                m_rs = sat(m_rs, m_desync, stat_clear);
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        s_axis_tvalid_l = 1'b0;
        s_axis_tvalid_r = 1'b0;
        stat_clear      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic vl, input logic [7:0] dl, input logic vr, input logic [7:0] dr);
        s_axis_tvalid_l = vl; s_axis_tdata_l = dl;
        s_axis_tvalid_r = vr; s_axis_tdata_r = dr;
        tick();
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_count"}, beat_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < beat_log.size(); i++)
            chk($sformatf("%s_beat%0d", nm, i), beat_log[i], exp_q[i]);
    endtask

    initial begin
        // Reset
        @(posedge sys_clk);
        #1;
        started = 1'b1;
        chk("rst_tready_l", s_axis_tready_l, 1);
        chk("rst_tready_r", s_axis_tready_r, 1);
        chk("rst_tvalid",   m_axis_tvalid, 0);
        chk("rst_drop_l",   drop_cnt_l, 0);
        chk("rst_resync",   resync_cnt, 0);
        sys_rst = 1'b0;

        // Basic interleave, each beat one cycle after its strobe
        beat_log.delete();
        strobe(1, 8'h11, 0, 0);
        strobe(0, 0, 1, 8'h22);
        strobe(1, 8'h33, 0, 0);
        strobe(0, 0, 1, 8'h44);
        ticks(3);
        exp_q = '{9'h011, 9'h122, 9'h033, 9'h144};
        check_log("t1");

        // Left overflow under stall
        beat_log.delete();
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 5; i++) strobe(1, 8'(i), 0, 0);
        chk("t2_drop_l", drop_cnt_l, 1);
        for (int i = 1; i <= 4; i++) strobe(0, 0, 1, 8'(8'h80 + i));
        m_axis_tready = 1'b1;
        ticks(10);
        exp_q = '{9'h001, 9'h181, 9'h002, 9'h182, 9'h003, 9'h183, 9'h004, 9'h184};
        check_log("t2");
        stat_clear = 1'b1;
        tick();
        chk("t2_clear_drop_l", drop_cnt_l, 0);

        // Desync: right fills while left is owed
        beat_log.delete();
        for (int i = 0; i < 4; i++) strobe(0, 0, 1, 8'(8'hC0 + i));
        ticks(3);
        chk("t3_resync", resync_cnt, 1);
        chk("t3_no_beats", beat_log.size(), 0);
        strobe(1, 8'hAA, 0, 0);
        strobe(0, 0, 1, 8'hBB);
        ticks(3);
        exp_q = '{9'h0AA, 9'h1BB};
        check_log("t3");

        // Pairs under alternating tready
        beat_log.delete();
        for (int i = 0; i < 4; i++) begin
            m_axis_tready = (i % 2 == 0);
            strobe(1, 8'(8'h40 + i), 1, 8'(8'h50 + i));
        end
        for (int i = 0; i < 14; i++) begin
            m_axis_tready = (i % 2 == 0);
            tick();
        end
        exp_q = '{9'h040, 9'h150, 9'h041, 9'h151, 9'h042, 9'h152, 9'h043, 9'h153};
        check_log("t4");

        // Drop counter saturation, then clear together with a drop
        beat_log.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 260; i++) strobe(1, 8'(i), 0, 0);
        chk("t5_drop_sat", drop_cnt_l, 255);
        stat_clear = 1'b1;
        strobe(1, 8'hEE, 0, 0);
        chk("t5_clear_with_drop", drop_cnt_l, 1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        m_axis_tready = 1'b1;
        ticks(2);
        chk("t5_no_beats", beat_log.size(), 0);

        // Enable falls during a stalled beat, so the beat is abandoned
        m_axis_tready = 1'b0;
        strobe(1, 8'h90, 0, 0);
        chk("t6_stalled_valid", m_axis_tvalid, 1);
        enable = 1'b0;
        tick();
        chk("t6_abandoned", m_axis_tvalid, 0);
        enable = 1'b1;
        m_axis_tready = 1'b1;
        ticks(3);
        chk("t6_no_beats", beat_log.size(), 0);

        // Reset mid-frame after an L beat
        beat_log.delete();
        strobe(1, 8'h61, 1, 8'h62);
        tick();
        exp_q = '{9'h061};
        check_log("t7_pre");
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("t7_drop_l", drop_cnt_l, 0);
        chk("t7_resync", resync_cnt, 0);
        chk("t7_tid",    m_axis_tid, 0);
        beat_log.delete();
        strobe(0, 0, 1, 8'h71);
        strobe(1, 8'h70, 0, 0);
        ticks(3);
        exp_q = '{9'h070, 9'h171};
        check_log("t7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
